// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// helper that sizes the bit counter from the operand width.
package bit_serial_adder_pkg;

  // Controller states; the encoding is fixed so external tools can decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Counter width: clog2 of the operand width, never less than one bit so a
  // one-bit adder still has a legal counter register.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage : bit_serial_adder_pkg

// File: rtl/bit_serial_adder_fa_cell.sv
// One-bit full adder used as the per-bit arithmetic engine of the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic prop_s;

  // Propagate term shared by the sum and carry equations.
  assign prop_s = a ^ b;
  assign sum    = prop_s ^ cin;
  assign carry  = (a & b) | (cin & prop_s);

endmodule : fa_cell

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: accepts a, b and cin with a valid/ready handshake, adds one
// bit per clock through a single full-adder cell (LSB first), and presents
// sum/cout with a valid/ready handshake. Synchronous active-low reset.
// Optional feature: define BIT_SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf (carry into MSB XOR carry out of MSB, held through DONE).
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_r;
  state_t           state_nxt_s;

  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;

  logic             fa_sum_s;
  logic             fa_carry_s;
  logic             last_bit_s;
  logic             accept_s;
  logic             release_s;

  // The bit being processed this cycle is the MSB when the counter hits WIDTH-1.
  assign last_bit_s = (cnt_r == CW'(WIDTH - 1));
  assign accept_s   = in_valid && (state_r == ST_IDLE);
  assign release_s  = out_ready && (state_r == ST_DONE);

  fa_cell u_fa (
    .a     (a_sr_r[0]),
    .b     (b_sr_r[0]),
    .cin   (carry_r),
    .sum   (fa_sum_s),
    .carry (fa_carry_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: accept -> run WIDTH bits -> hold result until taken.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (release_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs are pure decodes of the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ST_RUN: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
      ST_DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: load operands on accept, then shift one bit per RUN cycle.
  // Nothing here changes in DONE, which keeps sum/cout stable until released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_sr_r  <= a;
            b_sr_r  <= b;
            carry_r <= cin;
            cnt_r   <= '0;
          end
        end
        ST_RUN: begin
          a_sr_r  <= a_sr_r >> 1;
          b_sr_r  <= b_sr_r >> 1;
          sum_r   <= (sum_r >> 1) | (WIDTH'(fa_sum_s) << (WIDTH - 1));
          carry_r <= fa_carry_s;
          cnt_r   <= cnt_r + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = carry_r;

`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // Signed overflow: carry into the MSB (carry_r while the MSB is processed)
  // differs from the carry out of it; captured on the final RUN edge only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if ((state_r == ST_RUN) && last_bit_s) begin
      ovf_r <= carry_r ^ fa_carry_s;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule : bit_serial_adder

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder (WIDTH=8): directed operand sets are
// issued with hand-computed results pushed to a queue; a monitor pops and
// compares on every result handshake and checks accept-to-valid latency.
module tb_bit_serial_adder;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];
  int   acc_q[$];
  logic ov_prev = 1'b0;

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef BIT_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency and throughput measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  // Monitor: records accept edges, checks latency on out_valid rise, and
  // compares each handed-over result against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (!rst_n) begin
      acc_q.delete();
      ov_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) begin
          chk("latency_no_accept", 64'd1, 64'd0);
        end else begin
          k = acc_q.pop_front();
          chk("latency", 64'(cyc - k), 64'(WIDTH));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sum", 64'(sum), 64'(e.sum));
          chk("cout", 64'(cout), 64'(e.cout));
`ifdef BIT_SERIAL_ADDER_OVF_EN
          chk("ovf", 64'(ovf), 64'(e.ovf));
`endif
        end
      end
      ov_prev = out_valid;
    end
  end

  // Offer one operand set and wait (bounded) for the accept edge.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                       input exp_t e, input bit push, input bit keep, output int acc_cyc);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    cin = tc;
    if (push) exp_q.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!keep) in_valid = 1'b0;
  endtask

  // Wait (bounded) until every expected result has been consumed.
  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int   t;
    int   acc[4];
    bit   got;
    exp_t bb_exp[4];
    logic [7:0] bb_a[4];
    logic [7:0] bb_b[4];
    logic       bb_c[4];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'h00);
    chk("rst_cout", 64'(cout), 64'd0);
    @(posedge clk);
    #1;

    // Basic addition and wrap/overflow cases.
    out_ready = 1'b1;
    issue(8'h35, 8'h4A, 1'b0, '{8'h7F, 1'b0, 1'b0}, 1'b1, 1'b0, t);
    drain();
    issue(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0}, 1'b1, 1'b0, t);
    drain();
    issue(8'h7F, 8'h00, 1'b1, '{8'h80, 1'b0, 1'b1}, 1'b1, 1'b0, t);
    drain();

    // Consumer stall in DONE while new operands are offered.
    out_ready = 1'b0;
    issue(8'hC8, 8'h64, 1'b0, '{8'h2C, 1'b1, 1'b0}, 1'b1, 1'b0, t);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("stall_valid_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_sum", 64'(sum), 64'h2C);
      chk("stall_cout", 64'(cout), 64'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    exp_q.push_back('{8'h04, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();

    // Reset after three RUN edges aborts the operation.
    issue(8'hAA, 8'h55, 1'b0, '{8'hFF, 1'b0, 1'b0}, 1'b0, 1'b0, t);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    repeat (12) @(posedge clk);
    #1;
    issue(8'h10, 8'h20, 1'b0, '{8'h30, 1'b0, 1'b0}, 1'b1, 1'b0, t);
    drain();

    // Back-to-back operations with both handshakes held high.
    bb_a[0] = 8'h80; bb_b[0] = 8'h80; bb_c[0] = 1'b0; bb_exp[0] = '{8'h00, 1'b1, 1'b1};
    bb_a[1] = 8'h12; bb_b[1] = 8'h34; bb_c[1] = 1'b1; bb_exp[1] = '{8'h47, 1'b0, 1'b0};
    bb_a[2] = 8'hF0; bb_b[2] = 8'h0F; bb_c[2] = 1'b1; bb_exp[2] = '{8'h00, 1'b1, 1'b0};
    bb_a[3] = 8'h64; bb_b[3] = 8'h64; bb_c[3] = 1'b0; bb_exp[3] = '{8'hC8, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(bb_a[i], bb_b[i], bb_c[i], bb_exp[i], 1'b1, 1'b1, acc[i]);
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("b2b_interval", 64'(acc[i] - acc[i-1]), 64'(WIDTH + 2));
    end
    drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_bit_serial_adder
